// File: rtl/dctq_pkg.sv
// Shared types and default geometry for the dctq frame sequencer.
package dctq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_RDY,
    START,
    DRAIN,
    DONE
  } fsm_state_t;

  localparam int unsigned DEF_ROW_W    = 64;
  localparam int unsigned DEF_ROWS     = 8;
  localparam int unsigned DEF_COEF_W   = 9;
  localparam int unsigned DEF_COEFS    = 64;
  localparam int unsigned DEF_NUM_BLKS = 1024;

endpackage

// File: rtl/dctq_coef_reg.sv
// Registers the dctq coefficient stream, flags end-of-block and counts
// completed blocks for the current frame.
module dctq_coef_reg
  import dctq_pkg::*;
#(
  parameter int unsigned COEF_W   = DEF_COEF_W,
  parameter int unsigned COEFS    = DEF_COEFS,
  parameter int unsigned NUM_BLKS = DEF_NUM_BLKS,
  localparam int unsigned AD_W    = $clog2(COEFS),
  localparam int unsigned BC_W    = $clog2(NUM_BLKS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [COEF_W-1:0] dctq,
  input  logic              dctq_valid,
  input  logic [AD_W-1:0]   addr,
  output logic [COEF_W-1:0] coef_out,
  output logic              coef_valid,
  output logic              coef_last,
  output logic [BC_W-1:0]   blk_done
);

  logic [COEF_W-1:0] coef_out_q, coef_out_d;
  logic              coef_valid_q, coef_valid_d;
  logic              coef_last_q, coef_last_d;
  logic [BC_W-1:0]   blk_done_q, blk_done_d;
  logic              frame_over;
  logic              take;
  logic              eob;

  // Once the frame's last block has been emitted, trailing coefficients are dropped;
  // this gating is also what keeps blk_done saturated at NUM_BLKS.
  assign frame_over = (blk_done_q == BC_W'(NUM_BLKS));
  assign take       = dctq_valid & ~frame_over;
  assign eob        = take & (addr == AD_W'(COEFS - 1));

  always_comb begin
    coef_out_d   = coef_out_q;
    coef_valid_d = take;
    coef_last_d  = eob;
    blk_done_d   = blk_done_q;
    if (take) begin
      coef_out_d = dctq;
    end
    if (clr) begin
      blk_done_d = '0;
    end else if (eob) begin
      blk_done_d = blk_done_q + BC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_out_q   <= '0;
      coef_valid_q <= 1'b0;
      coef_last_q  <= 1'b0;
      blk_done_q   <= '0;
    end else begin
      coef_out_q   <= coef_out_d;
      coef_valid_q <= coef_valid_d;
      coef_last_q  <= coef_last_d;
      blk_done_q   <= blk_done_d;
    end
  end

  assign coef_out   = coef_out_q;
  assign coef_valid = coef_valid_q;
  assign coef_last  = coef_last_q;
  assign blk_done   = blk_done_q;

endmodule

// File: rtl/dctq_frame_ctrl.sv
// Frame sequencer around the dctq core: loads 8-row blocks, pulses start,
// registers coefficients back out and signals frame completion.
module dctq_frame_ctrl
  import dctq_pkg::*;
#(
  parameter int unsigned ROW_W    = DEF_ROW_W,
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned COEF_W   = DEF_COEF_W,
  parameter int unsigned COEFS    = DEF_COEFS,
  parameter int unsigned NUM_BLKS = DEF_NUM_BLKS,
  localparam int unsigned WA_W    = $clog2(ROWS),
  localparam int unsigned AD_W    = $clog2(COEFS),
  localparam int unsigned BC_W    = $clog2(NUM_BLKS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [ROW_W-1:0]   row_data,
  input  logic               row_valid,
  output logic               row_ready,
  output logic [ROW_W-1:0]   di,
  output logic [WA_W-1:0]    wa,
  output logic               din_valid,
  output logic [ROW_W/8-1:0] be,
  output logic               start,
  input  logic               dq_ready,
  output logic               hold,
  input  logic [COEF_W-1:0]  dctq,
  input  logic               dctq_valid,
  input  logic [AD_W-1:0]    addr,
  input  logic               coef_ready,
  output logic [COEF_W-1:0]  coef_out,
  output logic               coef_valid,
  output logic               coef_last,
  output logic [BC_W-1:0]    blk_done,
  output logic               frame_busy,
  output logic               frame_done
);

  fsm_state_t       state_q, state_d;
  logic [WA_W-1:0]  row_cnt_q, row_cnt_d;
  logic [BC_W-1:0]  blk_loaded_q, blk_loaded_d;
  logic             row_ready_q, row_ready_d;
  logic [ROW_W-1:0] di_q, di_d;
  logic [WA_W-1:0]  wa_q, wa_d;
  logic             din_valid_q, din_valid_d;
  logic             start_q, start_d;
  logic             frame_busy_q, frame_busy_d;
  logic             frame_done_q, frame_done_d;
  logic             row_acc;
  logic             fs_acc;

  assign row_acc = row_valid & row_ready_q;
  assign fs_acc  = frame_start & (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    blk_loaded_d = blk_loaded_q;
    di_d         = di_q;
    wa_d         = wa_q;
    din_valid_d  = row_acc;
    if (row_acc) begin
      di_d = row_data;
      wa_d = row_cnt_q;
    end
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d      = LOAD;
          row_cnt_d    = '0;
          blk_loaded_d = '0;
        end
      end
      LOAD: begin
        if (row_acc) begin
          if (row_cnt_q == WA_W'(ROWS - 1)) begin
            row_cnt_d = '0;
            state_d   = WAIT_RDY;
          end else begin
            row_cnt_d = row_cnt_q + WA_W'(1);
          end
        end
      end
      WAIT_RDY: begin
        if (dq_ready) begin
          state_d = START;
        end
      end
      START: begin
        blk_loaded_d = blk_loaded_q + BC_W'(1);
        state_d      = (blk_loaded_d == BC_W'(NUM_BLKS)) ? DRAIN : LOAD;
      end
      DRAIN: begin
        if (blk_done == BC_W'(NUM_BLKS)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are decoded from the next state so they are registered yet aligned with it.
    row_ready_d  = (state_d == LOAD);
    start_d      = (state_d == START);
    frame_busy_d = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      row_cnt_q    <= '0;
      blk_loaded_q <= '0;
      row_ready_q  <= 1'b0;
      di_q         <= '0;
      wa_q         <= '0;
      din_valid_q  <= 1'b0;
      start_q      <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      blk_loaded_q <= blk_loaded_d;
      row_ready_q  <= row_ready_d;
      di_q         <= di_d;
      wa_q         <= wa_d;
      din_valid_q  <= din_valid_d;
      start_q      <= start_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  dctq_coef_reg #(
    .COEF_W   (COEF_W),
    .COEFS    (COEFS),
    .NUM_BLKS (NUM_BLKS)
  ) u_coef_reg (
    .clk        (clk),
    .reset      (reset),
    .clr        (fs_acc),
    .dctq       (dctq),
    .dctq_valid (dctq_valid),
    .addr       (addr),
    .coef_out   (coef_out),
    .coef_valid (coef_valid),
    .coef_last  (coef_last),
    .blk_done   (blk_done)
  );

  assign row_ready  = row_ready_q;
  assign di         = di_q;
  assign wa         = wa_q;
  assign din_valid  = din_valid_q;
  assign be         = '0;
  assign start      = start_q;
  assign hold       = ~coef_ready;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dctq_frame_ctrl.sv
// Directed bench for dctq_frame_ctrl with a two-block frame.
module tb_dctq_frame_ctrl;

  localparam int unsigned NB = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [63:0] row_data;
  logic        row_valid;
  logic        row_ready;
  logic [63:0] di;
  logic [2:0]  wa;
  logic        din_valid;
  logic [7:0]  be;
  logic        start;
  logic        dq_ready;
  logic        hold;
  logic [8:0]  dctq;
  logic        dctq_valid;
  logic [5:0]  addr;
  logic        coef_ready;
  logic [8:0]  coef_out;
  logic        coef_valid;
  logic        coef_last;
  logic [1:0]  blk_done;
  logic        frame_busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;
  int nstart   = 0;
  int nvalid   = 0;

  always #5 clk = ~clk;

  dctq_frame_ctrl #(
    .ROW_W    (64),
    .ROWS     (8),
    .COEF_W   (9),
    .COEFS    (64),
    .NUM_BLKS (NB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .row_data    (row_data),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .di          (di),
    .wa          (wa),
    .din_valid   (din_valid),
    .be          (be),
    .start       (start),
    .dq_ready    (dq_ready),
    .hold        (hold),
    .dctq        (dctq),
    .dctq_valid  (dctq_valid),
    .addr        (addr),
    .coef_ready  (coef_ready),
    .coef_out    (coef_out),
    .coef_valid  (coef_valid),
    .coef_last   (coef_last),
    .blk_done    (blk_done),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic        fs;
    logic        rv;
    logic [63:0] rd;
    logic        dqr;
    logic        e_dv;
    logic [2:0]  e_wa;
    logic        e_rr;
    logic        e_st;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [63:0] rowv(input int k);
    return {32'hC0DE_F00D ^ 32'(k), 32'(k * 7 + 1)};
  endfunction

  function automatic logic [8:0] coefv(input int b, input int a);
    return 9'((b * 64 + a) * 5 + 3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_row_ready"}, 64'(row_ready), 64'd0);
    chk({tag, "_din_valid"}, 64'(din_valid), 64'd0);
    chk({tag, "_di"}, di, 64'd0);
    chk({tag, "_wa"}, 64'(wa), 64'd0);
    chk({tag, "_start"}, 64'(start), 64'd0);
    chk({tag, "_coef_valid"}, 64'(coef_valid), 64'd0);
    chk({tag, "_coef_last"}, 64'(coef_last), 64'd0);
    chk({tag, "_coef_out"}, 64'(coef_out), 64'd0);
    chk({tag, "_blk_done"}, 64'(blk_done), 64'd0);
    chk({tag, "_frame_busy"}, 64'(frame_busy), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    row_data    = '0;
    row_valid   = 1'b0;
    dq_ready    = 1'b0;
    dctq        = '0;
    dctq_valid  = 1'b0;
    addr        = '0;
    coef_ready  = 1'b1;

    // fs, rv, rd, dqr | dv, wa, rr, start
    tbl[0]  = '{1'b1, 1'b0, 64'd0,    1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, rowv(0),  1'b0, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, rowv(1),  1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, rowv(2),  1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 64'd0,    1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 64'd0,    1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, rowv(3),  1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, rowv(4),  1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, rowv(5),  1'b0, 1'b1, 3'd5, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, rowv(6),  1'b0, 1'b1, 3'd6, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, rowv(7),  1'b0, 1'b1, 3'd7, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, rowv(99), 1'b0, 1'b0, 3'd7, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, rowv(98), 1'b0, 1'b0, 3'd7, 1'b0, 1'b0};

    // reset state
    tick();
    tick();
    chk_all_zero("reset");
    chk("reset_be", 64'(be), 64'd0);
    chk("reset_hold", 64'(hold), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 64'(frame_busy), 64'd0);

    // block 0: row gaps, frame_start ignored in LOAD, dq_ready held low
    for (int i = 0; i < 14; i++) begin
      frame_start = tbl[i].fs;
      row_valid   = tbl[i].rv;
      row_data    = tbl[i].rd;
      dq_ready    = tbl[i].dqr;
      tick();
      frame_start = 1'b0;
      if (start) nstart++;
      chk($sformatf("tbl%0d_din_valid", i), 64'(din_valid), 64'(tbl[i].e_dv));
      chk($sformatf("tbl%0d_wa", i), 64'(wa), 64'(tbl[i].e_wa));
      chk($sformatf("tbl%0d_row_ready", i), 64'(row_ready), 64'(tbl[i].e_rr));
      chk($sformatf("tbl%0d_start", i), 64'(start), 64'(tbl[i].e_st));
      chk($sformatf("tbl%0d_busy", i), 64'(frame_busy), 64'd1);
      if (tbl[i].e_dv) chk($sformatf("tbl%0d_di", i), di, tbl[i].rd);
    end
    for (int i = 0; i < 18; i++) begin
      tick();
      if (start) nstart++;
      chk($sformatf("wait%0d_start", i), 64'(start), 64'd0);
      chk($sformatf("wait%0d_row_ready", i), 64'(row_ready), 64'd0);
      chk($sformatf("wait%0d_din_valid", i), 64'(din_valid), 64'd0);
    end
    row_valid = 1'b0;
    dq_ready  = 1'b1;
    tick();
    if (start) nstart++;
    chk("blk0_start", 64'(start), 64'd1);
    chk("blk0_start_rr", 64'(row_ready), 64'd0);
    tick();
    if (start) nstart++;
    chk("blk0_start_end", 64'(start), 64'd0);
    chk("blk1_load_rr", 64'(row_ready), 64'd1);

    // block 1: back-to-back rows
    for (int i = 0; i < 8; i++) begin
      row_valid = 1'b1;
      row_data  = rowv(8 + i);
      tick();
      if (start) nstart++;
      chk($sformatf("blk1_row%0d_dv", i), 64'(din_valid), 64'd1);
      chk($sformatf("blk1_row%0d_wa", i), 64'(wa), 64'(i));
      chk($sformatf("blk1_row%0d_di", i), di, rowv(8 + i));
      chk($sformatf("blk1_row%0d_rr", i), 64'(row_ready), (i == 7) ? 64'd0 : 64'd1);
    end
    row_valid = 1'b0;
    tick();
    if (start) nstart++;
    chk("blk1_start", 64'(start), 64'd1);
    tick();
    if (start) nstart++;
    chk("drain_start", 64'(start), 64'd0);
    chk("drain_rr", 64'(row_ready), 64'd0);
    chk("drain_busy", 64'(frame_busy), 64'd1);
    chk("start_pulses", 64'(nstart), 64'd2);
    dq_ready = 1'b0;

    // coefficient stream: two full blocks
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 64; a++) begin
        dctq_valid = 1'b1;
        addr       = 6'(a);
        dctq       = coefv(b, a);
        if (b == 1 && a == 10) frame_start = 1'b1;
        if (b == 1 && a == 20) begin
          coef_ready = 1'b0;
          #1;
          chk("hold_low_ready", 64'(hold), 64'd1);
          coef_ready = 1'b1;
          #1;
          chk("hold_high_ready", 64'(hold), 64'd0);
        end
        tick();
        frame_start = 1'b0;
        if (coef_valid) nvalid++;
        chk($sformatf("c%0d_%0d_valid", b, a), 64'(coef_valid), 64'd1);
        chk($sformatf("c%0d_%0d_out", b, a), 64'(coef_out), 64'(coefv(b, a)));
        chk($sformatf("c%0d_%0d_last", b, a), 64'(coef_last), (a == 63) ? 64'd1 : 64'd0);
        chk($sformatf("c%0d_%0d_blk_done", b, a), 64'(blk_done),
            64'(b + ((a == 63) ? 1 : 0)));
        if (a == 10 || a == 63) begin
          chk($sformatf("c%0d_%0d_busy", b, a), 64'(frame_busy), 64'd1);
          chk($sformatf("c%0d_%0d_done", b, a), 64'(frame_done), 64'd0);
        end
      end
    end
    dctq_valid = 1'b0;
    tick();
    chk("frame_done_pulse", 64'(frame_done), 64'd1);
    chk("frame_done_busy", 64'(frame_busy), 64'd1);
    chk("frame_done_cv", 64'(coef_valid), 64'd0);
    chk("frame_done_blk", 64'(blk_done), 64'(NB));
    tick();
    chk("frame_done_end", 64'(frame_done), 64'd0);
    chk("frame_idle_busy", 64'(frame_busy), 64'd0);
    chk("coef_valid_count", 64'(nvalid), 64'd128);

    // coefficients after frame completion are dropped
    for (int i = 0; i < 7; i++) begin
      dctq_valid = 1'b1;
      addr       = (i == 6) ? 6'd63 : 6'(i);
      dctq       = 9'h1AB;
      tick();
      chk($sformatf("late%0d_valid", i), 64'(coef_valid), 64'd0);
      chk($sformatf("late%0d_last", i), 64'(coef_last), 64'd0);
      chk($sformatf("late%0d_blk_done", i), 64'(blk_done), 64'(NB));
    end
    dctq_valid = 1'b0;

    // new frame clears blk_done, then reset mid-LOAD
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("f2_blk_done_clr", 64'(blk_done), 64'd0);
    chk("f2_busy", 64'(frame_busy), 64'd1);
    chk("f2_rr", 64'(row_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      row_valid = 1'b1;
      row_data  = rowv(40 + i);
      tick();
      chk($sformatf("f2_row%0d_wa", i), 64'(wa), 64'(i));
    end
    row_valid = 1'b0;
    reset     = 1'b1;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    tick();
    chk("postreset_done", 64'(frame_done), 64'd0);
    chk("postreset_busy", 64'(frame_busy), 64'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    row_valid   = 1'b1;
    row_data    = rowv(77);
    tick();
    row_valid = 1'b0;
    chk("f3_row0_dv", 64'(din_valid), 64'd1);
    chk("f3_row0_wa", 64'(wa), 64'd0);
    chk("f3_row0_di", di, rowv(77));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
